seg_595_rx: RTL and testbench

Receive-side model of the two cascaded 74HC595 shift registers that drive the six-digit seven-segment display. It samples the serial `ds`/`shcp`/`stcp`/`oe` lines in the `sys_clk` domain and rebuilds each latched 14-bit word. It decodes the segment pattern and assembles complete six-digit display frames. It is used on-board as a loop-back monitor of the display path and in simulation as the checker for the display driver.

---
 rtl/seg_595_rx.sv | 204 ++++++++++++++++++++
 tb/tb_seg_595_rx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_595_rx.sv
// Receive-side model of two cascaded 74HC595s driving a six-digit 7-seg display.
// Rebuilds each latched 14-bit word, decodes segments and assembles six-digit frames.
module seg_595_rx #(
  parameter int TIMEOUT = 50_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        stcp,
  input  logic        shcp,
  input  logic        ds,
  input  logic        oe,
  output logic [5:0]  sel_out,
  output logic [7:0]  seg_out,
  output logic        word_vld,
  output logic        len_err,
  output logic        sel_err,
  output logic [23:0] disp_data,
  output logic [5:0]  disp_point,
  output logic [5:0]  disp_minus,
  output logic [5:0]  disp_blank,
  output logic [5:0]  code_err,
  output logic        disp_on,
  output logic        frame_vld
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  logic [2:0] stcp_q, shcp_q;
  logic [1:0] ds_q, oe_q;
  logic       stcp_rise, shcp_rise;
  logic [13:0] sr;
  logic [3:0]  bit_cnt;
  logic [5:0]  sel_nxt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stcp_q <= '0;
      shcp_q <= '0;
      ds_q   <= '0;
      oe_q   <= '0;
    end else begin
      stcp_q <= {stcp_q[1:0], stcp};
      shcp_q <= {shcp_q[1:0], shcp};
      ds_q   <= {ds_q[0], ds};
      oe_q   <= {oe_q[0], oe};
    end
  end

  assign stcp_rise = stcp_q[1] & ~stcp_q[2];
  assign shcp_rise = shcp_q[1] & ~shcp_q[2];

  // First bit shifted lands in sr[13] and belongs to sel[0]
  always_comb begin
    sel_nxt = '0;
    for (int k = 0; k < 6; k++) sel_nxt[k] = sr[13-k];
  end

  // Latch sees sr before a coincident shift, as the real part does
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sr       <= '0;
      bit_cnt  <= '0;
      sel_out  <= '0;
      seg_out  <= 8'hFF;
      word_vld <= 1'b0;
      len_err  <= 1'b0;
      sel_err  <= 1'b0;
      disp_on  <= 1'b0;
    end else begin
      disp_on  <= ~oe_q[1];
      word_vld <= stcp_rise;
      len_err  <= stcp_rise && (bit_cnt != 4'd14);
      sel_err  <= stcp_rise && !$onehot(sel_nxt);
      if (shcp_rise) sr <= {sr[12:0], ds_q[1]};
      if (stcp_rise) begin
        sel_out <= sel_nxt;
        seg_out <= sr[7:0];
        bit_cnt <= shcp_rise ? 4'd1 : 4'd0;
      end else if (shcp_rise && bit_cnt != 4'd15) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  logic [3:0] dec_nib;
  logic       dec_minus, dec_blank, dec_err;

  always_comb begin
    dec_nib   = 4'h0;
    dec_minus = 1'b0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_out[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h3F: dec_minus = 1'b1;
      7'h7F: dec_blank = 1'b1;
      default: begin
        dec_nib = 4'hF;
        dec_err = 1'b1;
      end
    endcase
  end

  state_t         state;
  logic [TW-1:0]  timer;
  logic [5:0]     seen, seen_n;
  logic [5:0][3:0] sh_nib, nib_n;
  logic [5:0]     sh_pt, sh_mn, sh_bl, sh_er;
  logic [5:0]     pt_n, mn_n, bl_n, er_n;
  logic           accept;

  assign accept = word_vld & ~len_err & ~sel_err;

  always_comb begin
    seen_n = seen;
    nib_n  = sh_nib;
    pt_n   = sh_pt;
    mn_n   = sh_mn;
    bl_n   = sh_bl;
    er_n   = sh_er;
    if (accept) begin
      for (int k = 0; k < 6; k++) begin
        if (sel_out[k]) begin
          seen_n[k] = 1'b1;
          nib_n[k]  = dec_nib;
          pt_n[k]   = ~seg_out[7];
          mn_n[k]   = dec_minus;
          bl_n[k]   = dec_blank;
          er_n[k]   = dec_err;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      seen       <= '0;
      sh_nib     <= '0;
      sh_pt      <= '0;
      sh_mn      <= '0;
      sh_bl      <= '0;
      sh_er      <= '0;
      disp_data  <= '0;
      disp_point <= '0;
      disp_minus <= '0;
      disp_blank <= '0;
      code_err   <= '0;
      frame_vld  <= 1'b0;
    end else begin
      frame_vld <= 1'b0;
      if (accept) begin
        sh_nib <= nib_n;
        sh_pt  <= pt_n;
        sh_mn  <= mn_n;
        sh_bl  <= bl_n;
        sh_er  <= er_n;
      end
      case (state)
        IDLE: if (accept) begin
          seen  <= seen_n;
          timer <= TW'(TIMEOUT - 1);
          state <= COLLECT;
        end
        COLLECT: begin
          if (accept && seen_n == 6'h3F) begin
            disp_data  <= nib_n;
            disp_point <= pt_n;
            disp_minus <= mn_n;
            disp_blank <= bl_n;
            code_err   <= er_n;
            frame_vld  <= 1'b1;
            seen       <= '0;
            state      <= IDLE;
          end else if (timer == '0) begin
            seen  <= '0;
            state <= IDLE;
          end else begin
            timer <= timer - 1'b1;
            if (accept) seen <= seen_n;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_595_rx.sv
// Bench for seg_595_rx: word/frame scoreboard built from the decode rules,
// directed scenarios plus randomized frames.
module tb_seg_595_rx;
  localparam int TO = 1000;

  logic sys_clk = 0, sys_rst_n = 0, stcp = 0, shcp = 0, ds = 0, oe = 1;
  logic [5:0]  sel_out;
  logic [7:0]  seg_out;
  logic        word_vld, len_err, sel_err, disp_on, frame_vld;
  logic [23:0] disp_data;
  logic [5:0]  disp_point, disp_minus, disp_blank, code_err;

  seg_595_rx #(.TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .stcp(stcp), .shcp(shcp), .ds(ds), .oe(oe),
    .sel_out(sel_out), .seg_out(seg_out), .word_vld(word_vld), .len_err(len_err),
    .sel_err(sel_err), .disp_data(disp_data), .disp_point(disp_point),
    .disp_minus(disp_minus), .disp_blank(disp_blank), .code_err(code_err),
    .disp_on(disp_on), .frame_vld(frame_vld)
  );

  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        len_e, sel_e, done;
    logic [23:0] data;
    logic [5:0]  pt, mn, bl, er;
  } wexp_t;

  wexp_t q[$];

  // 8-bit codes with dp off, indexed by digit value
  logic [7:0] SEG[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: bits shifted, frame-assembly shadow
  logic [13:0] m_sr;
  int          m_cnt;
  logic [5:0]  m_seen;
  logic [3:0]  m_nib[6];
  logic [5:0]  m_pt, m_mn, m_bl, m_er;
  int          m_first;

  task automatic model_reset();
    m_sr = '0; m_cnt = 0; m_seen = '0; m_first = 0;
  endtask

  task automatic dec(input logic [7:0] s, output logic [3:0] n, output logic mn, bl, er);
    n = 4'hF; mn = 0; bl = 0; er = 1;
    for (int i = 0; i < 16; i++)
      if (s[6:0] == SEG[i][6:0]) begin n = 4'(i); er = 0; end
    if (s[6:0] == 7'h3F) begin n = 0; mn = 1; er = 0; end
    if (s[6:0] == 7'h7F) begin n = 0; bl = 1; er = 0; end
  endtask

  task automatic model_latch();
    wexp_t w;
    logic [3:0] n;
    logic mn, bl, er;
    int k;
    // The most recent 14 shifted bits, oldest first, are sel0..sel5, seg7..seg0
    for (int i = 0; i < 6; i++) w.sel[i] = m_sr[13-i];
    w.seg   = m_sr[7:0];
    w.len_e = (m_cnt != 14);
    w.sel_e = ($countones(w.sel) != 1);
    w.done  = 0;
    w.data = '0; w.pt = '0; w.mn = '0; w.bl = '0; w.er = '0;
    m_cnt = 0;
    if (!w.len_e && !w.sel_e) begin
      if (m_seen != 0 && (cyc - m_first) > TO) m_seen = '0;
      if (m_seen == 0) m_first = cyc;
      k = 0;
      for (int i = 0; i < 6; i++) if (w.sel[i]) k = i;
      dec(w.seg, n, mn, bl, er);
      m_nib[k] = n; m_pt[k] = ~w.seg[7]; m_mn[k] = mn; m_bl[k] = bl; m_er[k] = er;
      m_seen[k] = 1;
      if (m_seen == 6'h3F) begin
        w.done = 1;
        for (int i = 0; i < 6; i++) w.data[4*i +: 4] = m_nib[i];
        w.pt = m_pt; w.mn = m_mn; w.bl = m_bl; w.er = m_er;
        m_seen = '0;
      end
    end
    q.push_back(w);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b, input logic with_latch);
    ds = b;
    tick(2);
    if (with_latch) model_latch();
    shcp = 1; stcp = with_latch;
    m_sr = {m_sr[12:0], b};
    m_cnt = with_latch ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
    tick(2);
    shcp = 0; stcp = 0;
    tick(2);
  endtask

  task automatic latch();
    model_latch();
    stcp = 1;
    tick(2);
    stcp = 0;
    tick(4);
  endtask

  task automatic shift_word(input logic [5:0] sel, input logic [7:0] seg);
    logic [13:0] v;
    for (int k = 0; k < 6; k++) v[13-k] = sel[k];
    v[7:0] = seg;
    for (int i = 13; i >= 0; i--) shift_bit(v[i], 0);
  endtask

  task automatic send_word(input logic [5:0] sel, input logic [7:0] seg);
    shift_word(sel, seg);
    latch();
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) shift_bit(1'($urandom), 0);
    latch();
  endtask

  task automatic do_reset();
    model_reset();
    sys_rst_n = 0;
    tick(3);
    chk("rst sel_out", sel_out, 6'h00);
    chk("rst seg_out", seg_out, 8'hFF);
    chk("rst disp_data", disp_data, 24'h0);
    chk("rst disp_on", disp_on, 1'b0);
    sys_rst_n = 1;
    tick(3);
  endtask

  // Compare process: every cycle, outputs against the scoreboard
  logic [5:0]  cur_sel;
  logic [7:0]  cur_seg;
  wexp_t       cw, pend;
  logic        fnext;
  logic [23:0] cur_data;
  logic [5:0]  cur_pt, cur_mn, cur_bl, cur_er;
  int          fcount = 0;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      cur_sel = '0; cur_seg = 8'hFF; fnext = 0;
      cur_data = '0; cur_pt = '0; cur_mn = '0; cur_bl = '0; cur_er = '0;
    end else begin
      logic popped;
      popped = 0;
      if (word_vld) begin
        if (q.size() == 0) chk("word_vld unexpected", 1, 0);
        else begin
          cw = q.pop_front();
          popped = 1;
          cur_sel = cw.sel;
          cur_seg = cw.seg;
        end
      end
      chk("len_err", len_err, popped ? cw.len_e : 1'b0);
      chk("sel_err", sel_err, popped ? cw.sel_e : 1'b0);
      chk("frame_vld", frame_vld, fnext);
      if (frame_vld) fcount++;
      if (fnext) begin
        cur_data = pend.data; cur_pt = pend.pt; cur_mn = pend.mn;
        cur_bl = pend.bl; cur_er = pend.er;
      end
      fnext = popped && cw.done;
      pend = cw;
    end
    chk("sel_out", sel_out, cur_sel);
    chk("seg_out", seg_out, cur_seg);
    chk("disp_data", disp_data, cur_data);
    chk("disp_point", disp_point, cur_pt);
    chk("disp_minus", disp_minus, cur_mn);
    chk("disp_blank", disp_blank, cur_bl);
    chk("code_err", code_err, cur_er);
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    logic [23:0] dd;
    logic [5:0] order[6];
    model_reset();
    tick(3);
    do_reset();

    // oe -> disp_on with sync lag
    oe = 0;
    tick(1);
    chk("disp_on lag", disp_on, 1'b0);
    tick(4);
    chk("disp_on on", disp_on, 1'b1);

    // Single word
    send_word(6'b000001, 8'hA4);
    chk("single sel", sel_out, 6'b000001);
    chk("single seg", seg_out, 8'hA4);

    // Full frame 1..6, dp on digit 2
    f0 = fcount;
    for (int d = 0; d < 6; d++)
      send_word(6'(1 << d), SEG[d+1] & ((d == 2) ? 8'h7F : 8'hFF));
    tick(2);
    chk("frame count", fcount - f0, 1);
    chk("frame data", disp_data, 24'h654321);
    chk("frame point", disp_point, 6'b000100);
    chk("frame flags", {disp_minus, disp_blank, code_err}, 18'h0);

    // Minus / blank / undecodable
    for (int d = 0; d < 6; d++)
      send_word(6'(1 << d), (d == 5) ? 8'hBF : (d == 4) ? 8'hFF : (d == 3) ? 8'h55 : SEG[d]);
    tick(2);
    dd = disp_data;
    chk("minus5", disp_minus, 6'b100000);
    chk("blank4", disp_blank, 6'b010000);
    chk("code_err3", code_err, 6'b001000);
    chk("digit3 F", dd[15:12], 4'hF);

    // Bad words leave frame state alone
    f0 = fcount;
    send_bits(13);
    send_word(6'b000011, 8'hC0);
    tick(4);
    chk("bad no frame", fcount - f0, 0);

    // Reset mid-word, then a clean word
    oe = 1;
    for (int i = 0; i < 7; i++) shift_bit(1'($urandom), 0);
    do_reset();
    chk("disp_on after rst", disp_on, 1'b0);
    send_word(6'b000100, 8'h92);
    chk("post-rst seg", seg_out, 8'h92);

    // Coincident shcp/stcp: latch excludes the coincident bit
    shift_word(6'b000010, 8'h99);
    shift_bit(1'b1, 1);
    tick(2);
    chk("coinc sel", sel_out, 6'b000010);
    chk("coinc seg", seg_out, 8'h99);
    send_bits(13);

    // Timeout discards a stale partial frame
    do_reset();
    for (int d = 0; d < 5; d++) send_word(6'(1 << d), SEG[d+1]);
    tick(TO + 200);
    f0 = fcount;
    for (int d = 0; d < 6; d++) send_word(6'(1 << d), SEG[d+7]);
    tick(2);
    chk("timeout frames", fcount - f0, 1);
    chk("timeout data", disp_data, 24'hCBA987);

    // Randomized frames
    for (int r = 0; r < 10; r++) begin
      int nx;
      for (int i = 0; i < 6; i++) order[i] = 6'(1 << i);
      for (int i = 5; i > 0; i--) begin
        int j;
        logic [5:0] t;
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      nx = $urandom_range(0, 2);
      for (int i = 0; i < nx; i++) begin
        if ($urandom_range(0, 1) == 0) send_bits($urandom_range(12, 15));
        else send_word(6'(1 << $urandom_range(0, 5)), 8'($urandom));
      end
      for (int i = 0; i < 6; i++) begin
        logic [7:0] s;
        case ($urandom_range(0, 3))
          0, 1: s = SEG[$urandom_range(0, 15)] & {1'($urandom), 7'h7F};
          2:    s = {1'($urandom), ($urandom_range(0, 1) == 0) ? 7'h3F : 7'h7F};
          default: s = 8'($urandom);
        endcase
        send_word(order[i], s);
      end
      tick(3);
      if (m_seen != 0) tick(TO + 100);
    end

    tick(10);
    chk("pending words", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
